hyper_phy_sched: RTL and testbench



---
 rtl/hyper_sched_pkg.sv | 25 ++
 rtl/hyper_phy_fsm.sv | 99 +++++++++
 rtl/hyper_phy_sched.sv | 159 +++++++++++++++
 tb/tb_hyper_phy_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyper_sched_pkg.sv
// rtl/hyper_sched_pkg.sv - shared types and SoC-derived defaults for the HyperBus PHY scheduler
package hyper_sched_pkg;

    localparam logic [63:0] HYAXIBase           = 64'h8000_0000;
    localparam logic [63:0] HyperRamSize        = 64'h400_0000;
    localparam int unsigned HyperbusNumPhys     = 2;
    localparam int unsigned NumChipsPerHyperbus = 2;
    localparam int unsigned DefNumReq           = 4;
    localparam int unsigned DefLenW             = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BURST = 2'd2
    } phy_state_e;

    typedef struct packed {
        logic [NumChipsPerHyperbus-1:0]   cs;
        logic [$clog2(HyperRamSize)-1:0]  addr;
        logic [DefLenW-1:0]               len;
        logic                             write;
        logic [$clog2(DefNumReq)-1:0]     id;
    } hyper_cmd_t;

endpackage

// File: rtl/hyper_phy_fsm.sv
// rtl/hyper_phy_fsm.sv - per-PHY command issue and burst completion sequencer
module hyper_phy_fsm
    import hyper_sched_pkg::*;
#(
    parameter int unsigned CsW   = NumChipsPerHyperbus,
    parameter int unsigned AddrW = $clog2(HyperRamSize),
    parameter int unsigned LenW  = DefLenW,
    parameter int unsigned IdW   = $clog2(DefNumReq),
    parameter type         cmd_t = hyper_cmd_t
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             gnt_i,
    input  cmd_t             cmd_i,
    output logic             idle_o,
    output logic             phy_valid_o,
    input  logic             phy_ready_i,
    output logic [CsW-1:0]   phy_cs_o,
    output logic [AddrW-1:0] phy_addr_o,
    output logic [LenW-1:0]  phy_len_o,
    output logic             phy_write_o,
    input  logic             phy_beat_i,
    output logic             done_valid_o,
    output logic [IdW-1:0]   done_id_o
);

    phy_state_e          state_q, state_d;
    cmd_t                cmd_q;
    logic [LenW-1:0]     cnt_q;
    logic                done_q;
    logic [IdW-1:0]      done_id_q;
    logic                last_beat;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // cnt holds the beats still owed after the current one, so zero marks the last beat
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cmd_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            if (gnt_i && state_q == IDLE) begin
                cmd_q <= cmd_i;
            end
            if (state_q == ISSUE && phy_ready_i) begin
                cnt_q <= cmd_q.len;
            end else if (state_q == BURST && phy_beat_i) begin
                cnt_q <= cnt_q - LenW'(1);
            end
            done_q    <= last_beat;
            done_id_q <= last_beat ? cmd_q.id : '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_beat   = 1'b0;
        idle_o      = 1'b0;
        phy_valid_o = 1'b0;
        phy_cs_o    = '0;
        phy_addr_o  = cmd_q.addr;
        phy_len_o   = cmd_q.len;
        phy_write_o = cmd_q.write;
        case (state_q)
            IDLE: begin
                idle_o = 1'b1;
                if (gnt_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                phy_valid_o = 1'b1;
                phy_cs_o    = cmd_q.cs;
                if (phy_ready_i) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (phy_beat_i && cnt_q == '0) begin
                    last_beat = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done_valid_o = done_q;
    assign done_id_o    = done_id_q;

endmodule

// File: rtl/hyper_phy_sched.sv
// rtl/hyper_phy_sched.sv - address decode and round-robin sharing of HyperBus PHYs among burst requesters
module hyper_phy_sched
    import hyper_sched_pkg::*;
#(
    parameter int unsigned NumReq   = DefNumReq,
    parameter int unsigned NumPhys  = HyperbusNumPhys,
    parameter int unsigned NumChips = NumChipsPerHyperbus,
    parameter logic [63:0] RamSize  = HyperRamSize,
    parameter logic [63:0] BaseAddr = HYAXIBase,
    parameter int unsigned LenW     = DefLenW
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumReq-1:0]                     req_valid_i,
    output logic [NumReq-1:0]                     req_ready_o,
    input  logic [NumReq*32-1:0]                  req_addr_i,
    input  logic [NumReq*LenW-1:0]                req_len_i,
    input  logic [NumReq-1:0]                     req_write_i,
    output logic                                  req_err_o,
    output logic [$clog2(NumReq)-1:0]             req_err_id_o,
    output logic [NumPhys-1:0]                    phy_valid_o,
    input  logic [NumPhys-1:0]                    phy_ready_i,
    output logic [NumPhys*NumChips-1:0]           phy_cs_o,
    output logic [NumPhys*$clog2(RamSize)-1:0]    phy_addr_o,
    output logic [NumPhys*LenW-1:0]               phy_len_o,
    output logic [NumPhys-1:0]                    phy_write_o,
    input  logic [NumPhys-1:0]                    phy_beat_i,
    output logic [NumPhys-1:0]                    done_valid_o,
    output logic [NumPhys*$clog2(NumReq)-1:0]     done_id_o
);

    localparam int unsigned IdW      = $clog2(NumReq);
    localparam int unsigned AddrW    = $clog2(RamSize);
    localparam logic [63:0] ChipSpan = RamSize * 64'(NumChips);
    localparam logic [63:0] WinSize  = ChipSpan * 64'(NumPhys);

    typedef struct packed {
        logic [NumChips-1:0] cs;
        logic [AddrW-1:0]    addr;
        logic [LenW-1:0]     len;
        logic                write;
        logic [IdW-1:0]      id;
    } cmd_t;

    logic [NumReq-1:0]   dec_err;
    logic [NumReq-1:0]   eligible;
    logic [NumPhys-1:0]  dec_phy_oh [NumReq];
    logic [NumChips-1:0] dec_cs     [NumReq];
    logic [AddrW-1:0]    dec_local  [NumReq];
    logic [NumPhys-1:0]  phy_idle;
    logic [NumPhys-1:0]  phy_gnt;

    logic [IdW-1:0]      rr_q;
    logic                gnt_valid;
    logic [IdW-1:0]      gnt_id;
    logic                gnt_err;
    cmd_t                gnt_cmd;
    logic                err_q;
    logic [IdW-1:0]      err_id_q;

    for (genvar i = 0; i < NumReq; i++) begin : g_dec
        logic [63:0]         addr64;
        logic [63:0]         off;
        logic [63:0]         q_phy;
        logic [63:0]         q_chip;
        logic [NumPhys-1:0]  phy_oh;

        assign addr64 = {32'h0, req_addr_i[i*32 +: 32]};
        assign off    = addr64 - BaseAddr;
        assign q_phy  = off / ChipSpan;
        assign q_chip = (off / RamSize) % 64'(NumChips);

        assign dec_err[i]   = (addr64 < BaseAddr) || (off >= WinSize);
        assign dec_local[i] = off[AddrW-1:0];

        for (genvar p = 0; p < NumPhys; p++) begin : g_phy
            assign phy_oh[p] = (q_phy == 64'(p));
        end
        for (genvar c = 0; c < NumChips; c++) begin : g_chip
            assign dec_cs[i][c] = (q_chip == 64'(c));
        end
        assign dec_phy_oh[i] = phy_oh;

        // error requests never touch a PHY, so they compete regardless of PHY occupancy
        assign eligible[i] = req_valid_i[i] && (dec_err[i] || (|(phy_oh & phy_idle)));
    end

    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_id    = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            idx = (32'(rr_q) + k) % NumReq;
            if (!gnt_valid && eligible[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = IdW'(idx);
            end
        end
    end

    assign gnt_err     = dec_err[gnt_id];
    assign req_ready_o = gnt_valid ? (NumReq'(1) << gnt_id) : '0;

    always_comb begin
        gnt_cmd       = '0;
        gnt_cmd.cs    = dec_cs[gnt_id];
        gnt_cmd.addr  = dec_local[gnt_id];
        gnt_cmd.len   = req_len_i[gnt_id*LenW +: LenW];
        gnt_cmd.write = req_write_i[gnt_id];
        gnt_cmd.id    = gnt_id;
        for (int unsigned p = 0; p < NumPhys; p++) begin
            phy_gnt[p] = gnt_valid && !gnt_err && dec_phy_oh[gnt_id][p];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            err_q    <= 1'b0;
            err_id_q <= '0;
        end else begin
            if (gnt_valid) begin
                rr_q <= (gnt_id == IdW'(NumReq - 1)) ? '0 : gnt_id + IdW'(1);
            end
            err_q    <= gnt_valid && gnt_err;
            err_id_q <= (gnt_valid && gnt_err) ? gnt_id : '0;
        end
    end

    assign req_err_o    = err_q;
    assign req_err_id_o = err_id_q;

    for (genvar p = 0; p < NumPhys; p++) begin : g_fsm
        hyper_phy_fsm #(
            .CsW   (NumChips),
            .AddrW (AddrW),
            .LenW  (LenW),
            .IdW   (IdW),
            .cmd_t (cmd_t)
        ) u_fsm (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .gnt_i        (phy_gnt[p]),
            .cmd_i        (gnt_cmd),
            .idle_o       (phy_idle[p]),
            .phy_valid_o  (phy_valid_o[p]),
            .phy_ready_i  (phy_ready_i[p]),
            .phy_cs_o     (phy_cs_o[p*NumChips +: NumChips]),
            .phy_addr_o   (phy_addr_o[p*AddrW +: AddrW]),
            .phy_len_o    (phy_len_o[p*LenW +: LenW]),
            .phy_write_o  (phy_write_o[p]),
            .phy_beat_i   (phy_beat_i[p]),
            .done_valid_o (done_valid_o[p]),
            .done_id_o    (done_id_o[p*IdW +: IdW])
        );
    end

endmodule

// File: tb/tb_hyper_phy_sched.sv
// tb/tb_hyper_phy_sched.sv - self-checking bench for hyper_phy_sched
module tb_hyper_phy_sched;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_addr;
    logic [31:0]  req_len;
    logic [3:0]   req_write;
    logic         req_err;
    logic [1:0]   req_err_id;
    logic [1:0]   phy_valid;
    logic [1:0]   phy_ready;
    logic [3:0]   phy_cs;
    logic [51:0]  phy_addr;
    logic [15:0]  phy_len;
    logic [1:0]   phy_write;
    logic [1:0]   phy_beat;
    logic [1:0]   done_valid;
    logic [3:0]   done_id;

    always #5 clk = ~clk;

    hyper_phy_sched dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_len_i    (req_len),
        .req_write_i  (req_write),
        .req_err_o    (req_err),
        .req_err_id_o (req_err_id),
        .phy_valid_o  (phy_valid),
        .phy_ready_i  (phy_ready),
        .phy_cs_o     (phy_cs),
        .phy_addr_o   (phy_addr),
        .phy_len_o    (phy_len),
        .phy_write_o  (phy_write),
        .phy_beat_i   (phy_beat),
        .done_valid_o (done_valid),
        .done_id_o    (done_id)
    );

    int checks = 0;
    int errors = 0;

    // reference model: PHY activity 0 = free, 1 = command offered, 2 = beats outstanding
    int         rr;
    bit         m_err;
    int         m_err_id;
    int         mst [2];
    int         mleft [2];
    int         mown [2];
    logic [1:0] mcs [2];
    int         maddr [2];
    int         mlen [2];
    bit         mwr [2];
    bit         mdone [2];
    int         mdone_id [2];

    logic [3:0] keep, s_ready;
    logic [1:0] rdy_en, beat_en, s_valid, s_done;
    logic       s_err;
    logic [1:0] s_err_id;
    logic [3:0] s_done_id;
    int         glog [$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic void decode(input logic [31:0] a, output bit err, output int phy,
                                   output logic [1:0] cs, output int loc);
        longint unsigned off;
        off = {32'h0, a} - 64'h8000_0000;
        err = (a < 32'h8000_0000) || (off >= 64'h1000_0000);
        phy = 0; cs = 2'b00; loc = 0;
        if (!err) begin
            phy = int'(off / 64'h800_0000);
            cs  = (((off / 64'h400_0000) % 2) == 1) ? 2'b10 : 2'b01;
            loc = int'(off % 64'h400_0000);
        end
    endfunction

    task automatic model_reset();
        rr = 0; m_err = 0; m_err_id = 0;
        for (int p = 0; p < 2; p++) begin
            mst[p] = 0; mleft[p] = 0; mown[p] = 0; mcs[p] = 2'b00;
            maddr[p] = 0; mlen[p] = 0; mwr[p] = 0; mdone[p] = 0; mdone_id[p] = 0;
        end
    endtask

    task automatic drive_phy();
        for (int p = 0; p < 2; p++) begin
            phy_ready[p] = rdy_en[p] && (mst[p] == 1);
            phy_beat[p]  = beat_en[p] && (mst[p] == 2);
        end
    endtask

    task automatic step();
        int g, ph, loc, idx;
        bit e;
        logic [1:0] cs;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < 4; k++) begin
            idx = (rr + k) % 4;
            if (g < 0 && req_valid[idx]) begin
                decode(req_addr[idx*32 +: 32], e, ph, cs, loc);
                if (e || mst[ph] == 0) g = idx;
            end
        end
        chk("req_ready", req_ready, (g >= 0) ? 4'(1 << g) : 4'b0);
        chk("req_err", req_err, m_err);
        if (m_err) chk("req_err_id", req_err_id, m_err_id);
        for (int p = 0; p < 2; p++) begin
            chk("phy_valid", phy_valid[p], mst[p] == 1);
            chk("phy_cs", phy_cs[p*2 +: 2], (mst[p] == 1) ? mcs[p] : 2'b00);
            if (mst[p] == 1) begin
                chk("phy_addr", phy_addr[p*26 +: 26], maddr[p]);
                chk("phy_len", phy_len[p*8 +: 8], mlen[p]);
                chk("phy_write", phy_write[p], mwr[p]);
            end
            chk("done_valid", done_valid[p], mdone[p]);
            if (mdone[p]) chk("done_id", done_id[p*2 +: 2], mdone_id[p]);
            if (phy_beat[p]) chk("beat_only_in_burst", mst[p], 2);
        end
        s_ready = req_ready; s_err = req_err; s_err_id = req_err_id;
        s_valid = phy_valid; s_done = done_valid; s_done_id = done_id;
        for (int i = 0; i < 4; i++) if (req_ready[i]) glog.push_back(i);
        if (!rst_ni) begin
            model_reset();
        end else begin
            m_err = 0;
            for (int p = 0; p < 2; p++) begin
                mdone[p] = 0;
                if (mst[p] == 1 && phy_ready[p]) begin
                    mst[p] = 2; mleft[p] = mlen[p];
                end else if (mst[p] == 2 && phy_beat[p]) begin
                    if (mleft[p] == 0) begin
                        mst[p] = 0; mdone[p] = 1; mdone_id[p] = mown[p];
                    end else begin
                        mleft[p]--;
                    end
                end
            end
            if (g >= 0) begin
                decode(req_addr[g*32 +: 32], e, ph, cs, loc);
                if (e) begin
                    m_err = 1; m_err_id = g;
                end else begin
                    mst[ph] = 1; mcs[ph] = cs; maddr[ph] = loc;
                    mlen[ph] = int'(req_len[g*8 +: 8]); mwr[ph] = req_write[g]; mown[ph] = g;
                end
                rr = (g + 1) % 4;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (s_ready[i] && !keep[i]) req_valid[i] = 1'b0;
        drive_phy();
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [7:0] l, input bit w);
        req_addr[i*32 +: 32] = a;
        req_len[i*8 +: 8]    = l;
        req_write[i]         = w;
        req_valid[i]         = 1'b1;
    endtask

    task automatic run_until_idle(input int max);
        int n;
        n = 0;
        while ((mst[0] != 0 || mst[1] != 0 || req_valid != 0 || m_err || mdone[0] || mdone[1]) && n < max) begin
            step();
            n++;
        end
        if (n >= max) chk("idle_timeout", 0, 1);
    endtask

    task automatic reset_dut();
        req_valid = '0; keep = '0; rdy_en = '0; beat_en = '0;
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
    endtask

    initial begin
        int nb, n;
        bit got0, got1, overlap;
        logic [1:0] id0, id1;
        int exp_order [5];
        rst_ni = 1'b0; req_valid = '0; req_addr = '0; req_len = '0; req_write = '0;
        phy_ready = '0; phy_beat = '0; keep = '0; rdy_en = '0; beat_en = '0;
        model_reset();
        repeat (3) step();
        chk("rst_phy_valid", s_valid, 2'b00);
        chk("rst_req_err", s_err, 1'b0);
        chk("rst_done", s_done, 2'b00);
        chk("rst_phy_addr", phy_addr, 52'h0);
        chk("rst_phy_cs", phy_cs, 4'h0);
        rst_ni = 1'b1;

        // single write burst to PHY0 chip1
        issue(0, 32'h8400_0010, 8'd3, 1'b1);
        step();
        chk("t1_ready", s_ready, 4'b0001);
        chk("t1_valid", phy_valid, 2'b01);
        chk("t1_cs", phy_cs[1:0], 2'b10);
        chk("t1_addr", phy_addr[25:0], 26'h10);
        chk("t1_len", phy_len[7:0], 8'd3);
        chk("t1_write", phy_write[0], 1'b1);
        step(); step();
        chk("t1_hold_valid", phy_valid, 2'b01);
        rdy_en[0] = 1'b1; beat_en[0] = 1'b1; drive_phy();
        nb = 0; n = 0;
        while (n < 20) begin
            nb += int'(phy_beat[0]);
            step();
            n++;
            if (s_done[0]) break;
        end
        chk("t1_done_seen", s_done[0], 1'b1);
        chk("t1_beats", nb, 4);
        chk("t1_done_id", s_done_id[1:0], 2'd0);
        run_until_idle(20);

        // two requesters to different PHYs in the same cycle
        reset_dut();
        issue(1, 32'h8000_0000, 8'd2, 1'b0);
        issue(2, 32'h8800_0000, 8'd1, 1'b1);
        step();
        chk("t2_first_grant", s_ready, 4'b0010);
        step();
        chk("t2_second_grant", s_ready, 4'b0100);
        chk("t2_both_valid", phy_valid, 2'b11);
        chk("t2_cs", phy_cs, 4'b0101);
        rdy_en = 2'b11; beat_en = 2'b11; drive_phy();
        got0 = 0; got1 = 0; overlap = 0; id0 = 2'd3; id1 = 2'd3; n = 0;
        while (!(got0 && got1) && n < 30) begin
            if (phy_beat == 2'b11) overlap = 1;
            step();
            n++;
            if (s_done[0]) begin got0 = 1; id0 = s_done_id[1:0]; end
            if (s_done[1]) begin got1 = 1; id1 = s_done_id[3:2]; end
        end
        chk("t2_overlap", overlap, 1'b1);
        chk("t2_done0_id", id0, 2'd1);
        chk("t2_done1_id", id1, 2'd2);
        run_until_idle(20);

        // contention on PHY0: req3 waits for PHY0 to drain
        reset_dut();
        issue(0, 32'h8000_0100, 8'd1, 1'b0);
        issue(3, 32'h8000_0100, 8'd0, 1'b1);
        step();
        chk("t3_first_grant", s_ready, 4'b0001);
        rdy_en[0] = 1'b1; beat_en[0] = 1'b1; drive_phy();
        n = 0;
        while (n < 30) begin
            step();
            n++;
            if (s_ready[3]) break;
        end
        chk("t3_req3_granted", s_ready, 4'b1000);
        chk("t3_grant_with_done", s_done[0], 1'b1);
        chk("t3_done_id", s_done_id[1:0], 2'd0);
        run_until_idle(20);

        // decode errors above the window and below the base, then the last legal word
        issue(2, 32'h9000_0000, 8'd0, 1'b0);
        step();
        chk("t4_hi_ready", s_ready, 4'b0100);
        step();
        chk("t4_hi_err", s_err, 1'b1);
        chk("t4_hi_err_id", s_err_id, 2'd2);
        chk("t4_hi_no_phy", s_valid, 2'b00);
        issue(2, 32'h7FFF_FFFC, 8'd0, 1'b0);
        step();
        chk("t4_lo_ready", s_ready, 4'b0100);
        step();
        chk("t4_lo_err", s_err, 1'b1);
        chk("t4_lo_err_id", s_err_id, 2'd2);
        chk("t4_lo_no_phy", s_valid, 2'b00);
        issue(1, 32'h8FFF_FFFC, 8'd0, 1'b0);
        step();
        chk("t4_top_valid", phy_valid, 2'b10);
        chk("t4_top_cs", phy_cs[3:2], 2'b10);
        chk("t4_top_addr", phy_addr[51:26], 26'h3FF_FFFC);
        rdy_en = 2'b11; beat_en = 2'b11; drive_phy();
        run_until_idle(20);

        // four requesters hammering PHY0
        reset_dut();
        glog.delete();
        rdy_en = 2'b11; beat_en = 2'b11; keep = 4'b1111;
        for (int i = 0; i < 4; i++) issue(i, 32'h8000_0000, 8'd0, 1'b0);
        n = 0;
        while (glog.size() < 5 && n < 60) begin
            step();
            n++;
        end
        keep = '0; req_valid = '0;
        exp_order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++)
            chk("t5_grant_order", (k < glog.size()) ? glog[k] : -1, exp_order[k]);
        run_until_idle(20);

        // reset while PHY0 is mid-burst
        reset_dut();
        rdy_en[0] = 1'b1;
        issue(0, 32'h8000_0000, 8'd5, 1'b1);
        n = 0;
        while (mst[0] != 2 && n < 10) begin
            step();
            n++;
        end
        step();
        chk("t6_in_burst", phy_valid, 2'b00);
        rst_ni = 1'b0;
        step();
        chk("t6_rst_valid", phy_valid, 2'b00);
        chk("t6_rst_cs", phy_cs, 4'h0);
        chk("t6_rst_addr", phy_addr, 52'h0);
        chk("t6_rst_len", phy_len, 16'h0);
        chk("t6_rst_write", phy_write, 2'b00);
        chk("t6_rst_done", done_valid, 2'b00);
        chk("t6_rst_err", req_err, 1'b0);
        rst_ni = 1'b1;
        beat_en[0] = 1'b1;
        step(); step();
        chk("t6_no_done", s_done, 2'b00);
        issue(1, 32'h8000_0040, 8'd0, 1'b0);
        step();
        chk("t6_new_grant", s_ready, 4'b0010);
        run_until_idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
